sender_controller: RTL and testbench

Sequencing controller that owns the `sender_memory` 16×16 buffer.
- Load phase: accepts words from an upstream producer over a valid/ready handshake and writes them into consecutive addresses starting at 0.
- Transmit phase: on `Start`, reads the stored words back in address order and presents them on a valid/ready output stream toward the sender datapath.
- The controller enforces the memory's access protocol: strobe timing, address/data hold, and idle gaps. Upstream and downstream logic never touch the memory directly.

---
 rtl/sender_controller.sv | 132 +++++++++++++
 tb/tb_sender_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sender_controller.sv
// Owns the 16x16 sender memory: loads words in address order, then streams them out on Start.
// Load costs 4 cycles per word; a read takes 3 cycles to TxValid. TxReady low holds TxData and stalls all memory access.
module sender_controller #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              LoadValid,
  input  logic [DATA_W-1:0] LoadData,
  output logic              LoadReady,
  input  logic              Start,
  output logic [DATA_W-1:0] TxData,
  output logic              TxValid,
  input  logic              TxReady,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataIn,
  output logic              MemReadEnable,
  output logic              MemWriteEnable,
  input  logic [DATA_W-1:0] MemDataOut
);

  typedef enum logic [2:0] {IDLE, WRITE_ACC, READ_ACC, TX, GAP, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  state_t            state;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W-1:0] read_ptr;
  logic              acc_cnt;
  logic              last_word;

  // Start has priority over a load offered in the same cycle.
  assign LoadReady = (state == IDLE) && (word_count < DEPTH_W) && !Start && !rst;
  assign last_word = ({1'b0, read_ptr} == (word_count - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      word_count     <= '0;
      read_ptr       <= '0;
      acc_cnt        <= 1'b0;
      TxData         <= '0;
      TxValid        <= 1'b0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      MemAddress     <= '0;
      MemDataIn      <= '0;
      MemReadEnable  <= 1'b0;
      MemWriteEnable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            if (word_count != '0) begin
              read_ptr      <= '0;
              MemAddress    <= '0;
              Busy          <= 1'b1;
              MemReadEnable <= 1'b1;
              acc_cnt       <= 1'b0;
              state         <= READ_ACC;
            end else begin
              Done  <= 1'b1;
              state <= DONE;
            end
          end else if (LoadValid && LoadReady) begin
            MemDataIn      <= LoadData;
            MemAddress     <= word_count[ADDR_W-1:0];
            MemWriteEnable <= 1'b1;
            acc_cnt        <= 1'b0;
            state          <= WRITE_ACC;
          end
        end
        WRITE_ACC: begin
          if (!acc_cnt) begin
            acc_cnt <= 1'b1;
          end else begin
            acc_cnt        <= 1'b0;
            MemWriteEnable <= 1'b0;
            word_count     <= word_count + 1'b1;
            state          <= GAP;
          end
        end
        READ_ACC: begin
          if (!acc_cnt) begin
            acc_cnt <= 1'b1;
          end else begin
            acc_cnt       <= 1'b0;
            MemReadEnable <= 1'b0;
            TxData        <= MemDataOut;
            TxValid       <= 1'b1;
            state         <= TX;
          end
        end
        TX: begin
          if (TxReady) begin
            TxValid <= 1'b0;
            if (last_word) begin
              Busy  <= 1'b0;
              Done  <= 1'b1;
              state <= DONE;
            end else begin
              read_ptr   <= read_ptr + 1'b1;
              MemAddress <= read_ptr + 1'b1;
              state      <= GAP;
            end
          end
        end
        // Busy distinguishes the transmit gap from the load gap.
        GAP: begin
          if (Busy) begin
            MemReadEnable <= 1'b1;
            acc_cnt       <= 1'b0;
            state         <= READ_ACC;
          end else begin
            state <= IDLE;
          end
        end
        DONE: begin
          Done       <= 1'b0;
          word_count <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sender_controller.sv
// Bench for sender_controller: behavioural memory, strobe-protocol monitor, queue-based word model,
// directed scenarios followed by randomized load/transmit rounds with random backpressure.
module tb_sender_controller;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              LoadValid = 1'b0;
  logic [DATA_W-1:0] LoadData = '0;
  logic              LoadReady;
  logic              Start = 1'b0;
  logic [DATA_W-1:0] TxData;
  logic              TxValid;
  logic              TxReady = 1'b0;
  logic              Busy;
  logic              Done;
  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemDataIn;
  logic              MemReadEnable;
  logic              MemWriteEnable;
  logic [DATA_W-1:0] MemDataOut;

  int n_checks = 0;
  int n_fail   = 0;
  int rst_cnt  = 0;
  int done_cnt = 0;
  int starts   = 0;

  logic [DATA_W-1:0] model[$];
  logic [DATA_W-1:0] mem[DEPTH];

  always #5 clk = ~clk;

  sender_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .LoadValid(LoadValid), .LoadData(LoadData), .LoadReady(LoadReady),
    .Start(Start), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
    .Busy(Busy), .Done(Done),
    .MemAddress(MemAddress), .MemDataIn(MemDataIn),
    .MemReadEnable(MemReadEnable), .MemWriteEnable(MemWriteEnable),
    .MemDataOut(MemDataOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Synchronous memory: read data appears the cycle after the first read-strobe cycle.
  always @(posedge clk) begin
    if (rst) rst_cnt <= rst_cnt + 1;
    if (MemWriteEnable) mem[MemAddress] <= MemDataIn;
    if (MemReadEnable) MemDataOut <= mem[MemAddress];
  end

  logic              prev_re = 1'b0;
  logic              prev_we = 1'b0;
  int                run_len = 0;
  int                run_rst = 0;
  logic [ADDR_W-1:0] run_addr = '0;
  logic [DATA_W-1:0] run_data = '0;

  always @(negedge clk) begin
    if (Done) done_cnt++;
    if (!MemReadEnable && !MemWriteEnable) begin
      if ((prev_re || prev_we) && run_rst == rst_cnt)
        check("strobe_len", 32'(run_len), 32'd2);
    end else begin
      check("strobe_excl", 32'(MemReadEnable & MemWriteEnable), 32'd0);
      if ((MemReadEnable && !prev_re) || (MemWriteEnable && !prev_we)) begin
        check("strobe_gap", 32'(prev_re | prev_we), 32'd0);
        run_len  = 1;
        run_rst  = rst_cnt;
        run_addr = MemAddress;
        run_data = MemDataIn;
      end else begin
        run_len++;
        check("addr_hold", 32'(MemAddress), 32'(run_addr));
        check("data_hold", 32'(MemDataIn), 32'(run_data));
      end
    end
    prev_re = MemReadEnable;
    prev_we = MemWriteEnable;
  end

  task automatic do_load(input logic [DATA_W-1:0] d);
    bit acc = 1'b0;
    bit exp_acc = (model.size() < DEPTH);
    LoadValid = 1'b1;
    LoadData  = d;
    for (int i = 0; i < 6 && !acc; i++) begin
      acc = LoadReady;
      @(negedge clk);
    end
    LoadValid = 1'b0;
    check("load_accept", 32'(acc), 32'(exp_acc));
    if (acc) begin
      check("wr_en_c1", 32'(MemWriteEnable), 32'd1);
      check("wr_addr", 32'(MemAddress), 32'(model.size()));
      check("wr_data", 32'(MemDataIn), 32'(d));
      @(negedge clk);
      check("wr_en_c2", 32'(MemWriteEnable), 32'd1);
      @(negedge clk);
      check("wr_gap", 32'(MemWriteEnable), 32'd0);
      check("gap_not_ready", 32'(LoadReady), 32'd0);
      model.push_back(d);
      @(negedge clk);
      check("ready_after_load", 32'(LoadReady), 32'(model.size() < DEPTH));
    end
  endtask

  task automatic do_tx(input bit collide, input int stall_word, input int max_stall);
    int n = model.size();
    int idx = 0;
    int cyc = 0;
    int last = 0;
    int stall = 0;
    bit seen = 1'b0;
    logic [DATA_W-1:0] held = '0;
    starts++;
    Start = 1'b1;
    if (collide) begin
      LoadValid = 1'b1;
      LoadData  = 16'hBEEF;
      #1 check("ready_on_start", 32'(LoadReady), 32'd0);
    end
    @(negedge clk);
    cyc = 1;
    Start = 1'b0;
    LoadValid = 1'b0;
    if (n == 0) begin
      check("empty_done", 32'(Done), 32'd1);
      check("empty_busy", 32'(Busy), 32'd0);
      check("empty_strobes", 32'({MemReadEnable, MemWriteEnable}), 32'd0);
      @(negedge clk);
      check("empty_done_clr", 32'(Done), 32'd0);
      check("empty_strobes2", 32'({MemReadEnable, MemWriteEnable}), 32'd0);
      return;
    end
    check("rd_first", 32'(MemReadEnable), 32'd1);
    check("rd_addr0", 32'(MemAddress), 32'd0);
    check("busy", 32'(Busy), 32'd1);
    while (idx < n && cyc < 400) begin
      if (TxValid) begin
        if (!seen) begin
          check("tx_latency", 32'(cyc - last), (idx == 0) ? 32'd3 : 32'd4);
          seen  = 1'b1;
          held  = TxData;
          stall = (idx == stall_word) ? 5 : int'($urandom_range(0, max_stall));
        end else begin
          check("tx_hold", 32'(TxData), 32'(held));
        end
        if (stall == 0) begin
          TxReady = 1'b1;
          check("tx_data", 32'(TxData), 32'(model[idx]));
          idx++;
          seen = 1'b0;
          last = cyc;
        end else begin
          TxReady = 1'b0;
          stall--;
          check("stall_no_strobe", 32'({MemReadEnable, MemWriteEnable}), 32'd0);
        end
      end else begin
        TxReady = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    check("tx_word_count", 32'(idx), 32'(n));
    check("done_pulse", 32'(Done), 32'd1);
    check("done_busy", 32'(Busy), 32'd0);
    check("done_txvalid", 32'(TxValid), 32'd0);
    model.delete();
    TxReady = 1'b0;
    @(negedge clk);
    check("done_clr", 32'(Done), 32'd0);
    check("ready_after_done", 32'(LoadReady), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(LoadReady), 32'd0);
    check("rst_flags", 32'({TxValid, Busy, Done, MemReadEnable, MemWriteEnable}), 32'd0);
    check("rst_txdata", 32'(TxData), 32'd0);
    check("rst_mem_bus", 32'({MemAddress, MemDataIn}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(LoadReady), 32'd1);

    // Three words, second one held off for five cycles.
    do_load(16'h1111);
    do_load(16'h2222);
    do_load(16'h3333);
    do_tx(1'b0, 1, 0);

    // Fill to capacity; the 17th offer must be refused.
    for (int i = 0; i < DEPTH; i++) do_load(16'hA000 + 16'(i));
    do_load(16'hA010);
    do_tx(1'b0, -1, 2);

    do_tx(1'b0, -1, 0);

    // Start and a load offer collide: only the stored words go out.
    do_load(16'h0C01);
    do_load(16'h0C02);
    do_tx(1'b1, -1, 1);
    check("beef_not_written", 32'(mem[2]), 32'hA002);

    // Reset during the first read access of a transmit.
    do_load(16'h7001);
    do_load(16'h7002);
    do_load(16'h7003);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check("pre_rst_read", 32'(MemReadEnable), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_flags", 32'({TxValid, Busy, Done, MemReadEnable, MemWriteEnable}), 32'd0);
    check("midrst_txdata", 32'(TxData), 32'd0);
    check("midrst_mem_bus", 32'({MemAddress, MemDataIn}), 32'd0);
    #1 check("midrst_ready", 32'(LoadReady), 32'd1);
    model.delete();
    @(negedge clk);
    do_load(16'h5A5A);
    do_tx(1'b0, -1, 0);

    for (int r = 0; r < 6; r++) begin
      int n = int'($urandom_range(0, 17));
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_load(16'($urandom));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_tx(1'($urandom_range(0, 1)), -1, 3);
    end

    check("done_count", 32'(done_cnt), 32'(starts));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
